// File: rtl/counter_seq_ctrl.sv
// Programmable interval timer: WIDTH-bit up-counter advanced by a prescaler,
// sequenced through idle/run/pause/done with host config and status pulses.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | stopped after reset or abort; q=0, config writes accepted
//   ST_RUN   | counting; q advances once every (prescale+1) cycles
//   ST_PAUSE | frozen; q and prescaler held until resume or abort
//   ST_DONE  | one-shot reached limit; q holds limit, config writes accepted
module counter_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PRE_W-1:0] pc_q, pc_d;

  // Host-visible config and the copy frozen at start; a same-edge write
  // therefore only affects the following start.
  logic [WIDTH-1:0] cfg_limit_q, cfg_limit_d;
  logic [PRE_W-1:0] cfg_pre_q, cfg_pre_d;
  logic             cfg_mode_q, cfg_mode_d;
  logic [WIDTH-1:0] run_limit_q, run_limit_d;
  logic [PRE_W-1:0] run_pre_q, run_pre_d;
  logic             run_mode_q, run_mode_d;

  logic tc_q, tc_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic cfg_err_q, cfg_err_d;

  logic cfg_open;
  logic tick;

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    pc_d        = pc_q;
    cfg_limit_d = cfg_limit_q;
    cfg_pre_d   = cfg_pre_q;
    cfg_mode_d  = cfg_mode_q;
    run_limit_d = run_limit_q;
    run_pre_d   = run_pre_q;
    run_mode_d  = run_mode_q;
    tc_d        = 1'b0;
    cfg_err_d   = 1'b0;
    tick        = 1'b0;
    cfg_open    = (state_q == ST_IDLE) || (state_q == ST_DONE);

    if (cfg_wr) begin
      if (cfg_open) begin
        cfg_limit_d = cfg_limit;
        cfg_pre_d   = cfg_prescale;
        cfg_mode_d  = cfg_mode;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          run_limit_d = cfg_limit_q;
          run_pre_d   = cfg_pre_q;
          run_mode_d  = cfg_mode_q;
          q_d         = '0;
          pc_d        = '0;
          if (cfg_limit_q == '0) begin
            state_d = ST_DONE;
            tc_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else begin
          if (pc_q == run_pre_q) begin
            pc_d = '0;
            tick = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
          // q saturates at limit: one-shot parks there, auto-reload restarts at 0
          if (tick) begin
            if (q_q != run_limit_q) begin
              q_d = q_q + 1'b1;
            end else begin
              tc_d = 1'b1;
              if (run_mode_q) begin
                q_d = '0;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
      end

      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          q_d     = '0;
          pc_d    = '0;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        q_d     = '0;
        pc_d    = '0;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      q_q         <= '0;
      pc_q        <= '0;
      cfg_limit_q <= '1;
      cfg_pre_q   <= '0;
      cfg_mode_q  <= 1'b0;
      run_limit_q <= '1;
      run_pre_q   <= '0;
      run_mode_q  <= 1'b0;
      tc_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      pc_q        <= pc_d;
      cfg_limit_q <= cfg_limit_d;
      cfg_pre_q   <= cfg_pre_d;
      cfg_mode_q  <= cfg_mode_d;
      run_limit_q <= run_limit_d;
      run_pre_q   <= run_pre_d;
      run_mode_q  <= run_mode_d;
      tc_q        <= tc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign q       = q_q;
  assign tc      = tc_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule
